// File: rtl/key_matrix_pkg.sv
// Shared types and sizing helpers for the key-matrix scanner and its
// frame debouncer.
package key_matrix_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRIVE     = 2'd1,
    SAMPLE    = 2'd2,
    FRAME_END = 2'd3
  } scan_state_e;

  // Counter width able to index n distinct values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 32'd1) begin
      cnt_width = 32'd1;
    end else begin
      cnt_width = w;
    end
  endfunction

endpackage

// File: rtl/key_frame_debouncer.sv
// Whole-frame debouncer for the key-matrix scanner. Accepts one raw frame per
// strobe, requires DEBOUNCE_SCANS consecutive identical frames before the
// stable key map changes, and emits a one-cycle mask of newly pressed keys.
// Optional build macro KEY_MATRIX_GHOST_REJECT_EN discards frames in which two
// rows share two or more pressed columns (the classic diode-less ghost pattern).
module key_frame_debouncer
  import key_matrix_pkg::*;
#(
  parameter int unsigned N              = 5,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N*N-1:0] raw_i,
  input  logic           strobe_i,
  output logic [N*N-1:0] pressed_o,
  output logic [N*N-1:0] new_press_o
);

  // The match counter must hold 0..DEBOUNCE_SCANS inclusive.
  localparam int unsigned MW = cnt_width(DEBOUNCE_SCANS + 32'd1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  logic [N*N-1:0] prev_q,      prev_d;
  logic [N*N-1:0] pressed_q,   pressed_d;
  logic [N*N-1:0] new_press_q, new_press_d;
  logic [MW-1:0]  match_q,     match_d;
  logic           ghost_s;

`ifdef KEY_MATRIX_GHOST_REJECT_EN
  // True when any pair of rows shares two or more pressed columns; such a
  // frame cannot be told apart from one containing phantom keys.
  function automatic logic frame_has_ghost(input logic [N*N-1:0] f);
    logic           g;
    logic [N-1:0]   shared;
    g = 1'b0;
    for (int a = 0; a < N; a++) begin
      for (int b = a + 1; b < N; b++) begin
        shared = f[a*N +: N] & f[b*N +: N];
        if ($countones(shared) > 1) begin
          g = 1'b1;
        end else begin
          g = g;
        end
      end
    end
    return g;
  endfunction

  assign ghost_s = frame_has_ghost(raw_i);
`else
  assign ghost_s = 1'b0;
`endif

  // Next-state for the debounce history and the stable key map, evaluated once per frame strobe.
  always_comb begin
    prev_d      = prev_q;
    match_d     = match_q;
    pressed_d   = pressed_q;
    new_press_d = '0;
    if (strobe_i) begin
      if (ghost_s) begin
        // Unusable frame: history restarts, key map is held.
        match_d = '0;
      end else begin
        prev_d = raw_i;
        if (raw_i == prev_q) begin
          if (match_q >= MATCH_MAX) begin
            match_d = MATCH_MAX;
          end else begin
            match_d = match_q + MATCH_ONE;
          end
        end else begin
          match_d = MATCH_ONE;
        end
        if ((match_d == MATCH_MAX) && (raw_i != pressed_q)) begin
          pressed_d   = raw_i;
          new_press_d = raw_i & ~pressed_q;
        end else begin
          pressed_d   = pressed_q;
          new_press_d = '0;
        end
      end
    end else begin
      match_d = match_q;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q      <= '0;
      match_q     <= '0;
      pressed_q   <= '0;
      new_press_q <= '0;
    end else begin
      prev_q      <= prev_d;
      match_q     <= match_d;
      pressed_q   <= pressed_d;
      new_press_q <= new_press_d;
    end
  end

  assign pressed_o   = pressed_q;
  assign new_press_o = new_press_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// N x N push-button matrix scanner. Drives one active-high column at a time,
// lets it settle for SETTLE_CYCLES clocks, captures the active-low rows into a
// raw frame, and hands each completed frame to key_frame_debouncer.
// A frame takes N*(SETTLE_CYCLES+1)+1 clocks. Build macro
// KEY_MATRIX_GHOST_REJECT_EN enables ghost-frame rejection in the debouncer.
module key_matrix_scanner
  import key_matrix_pkg::*;
#(
  parameter int unsigned N              = 5,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ena_i,
  output logic [N-1:0]   cols_o,
  input  logic [N-1:0]   rows_i,
  output logic [N*N-1:0] pressed_o,
  output logic [N*N-1:0] new_press_o,
  output logic           frame_done_o
);

  localparam int unsigned   COL_W       = cnt_width(N);
  localparam int unsigned   SET_W       = cnt_width(SETTLE_CYCLES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 32'd1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [N-1:0]     COL0_SEL = N'(1);

  scan_state_e      state_q;
  logic [COL_W-1:0] col_q;
  logic [SET_W-1:0] settle_q;
  logic [N-1:0]     cols_q;
  logic [N*N-1:0]   raw_q;
  logic             frame_done_q;

  // Scan sequencer: column stepping, settle timing, row capture and frame strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      col_q        <= '0;
      settle_q     <= '0;
      cols_q       <= '0;
      raw_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          col_q    <= '0;
          settle_q <= '0;
          if (ena_i) begin
            state_q <= DRIVE;
            cols_q  <= COL0_SEL;
          end else begin
            cols_q  <= '0;
          end
        end

        DRIVE: begin
          if (settle_q == SET_LAST) begin
            settle_q <= '0;
            state_q  <= SAMPLE;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end

        SAMPLE: begin
          // Column still driven this cycle; a low row means a closed switch.
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              if (col_q == COL_W'(c)) begin
                raw_q[r*N + c] <= ~rows_i[r];
              end
            end
          end
          if (col_q == COL_LAST) begin
            state_q      <= FRAME_END;
            cols_q       <= '0;
            frame_done_q <= 1'b1;
          end else begin
            col_q   <= col_q + COL_W'(1);
            cols_q  <= cols_q << 1'b1;
            state_q <= DRIVE;
          end
        end

        FRAME_END: begin
          // ena is only honoured here, so a frame is never cut short.
          col_q    <= '0;
          settle_q <= '0;
          if (ena_i) begin
            state_q <= DRIVE;
            cols_q  <= COL0_SEL;
          end else begin
            state_q <= IDLE;
            cols_q  <= '0;
          end
        end

        default: begin
          state_q  <= IDLE;
          col_q    <= '0;
          settle_q <= '0;
          cols_q   <= '0;
        end
      endcase
    end
  end

  key_frame_debouncer #(
    .N              (N),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .raw_i       (raw_q),
    .strobe_i    (frame_done_q),
    .pressed_o   (pressed_o),
    .new_press_o (new_press_o)
  );

  assign cols_o       = cols_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench for key_matrix_scanner (N=5, SETTLE_CYCLES=2,
// DEBOUNCE_SCANS=3). A simulated switch matrix answers the column drive; a
// frame-history reference model predicts pressed / new_press every cycle.
module tb_key_matrix_scanner;

  localparam int N  = 5;
  localparam int SC = 2;
  localparam int DS = 3;
  localparam int NK = N * N;
  localparam int FRAME_LEN = N * (SC + 1) + 1;

  localparam logic [NK-1:0] K0  = NK'(1);
  localparam logic [NK-1:0] K13 = NK'(1) << 13;
  localparam logic [NK-1:0] KG  = (NK'(1) << 0) | (NK'(1) << 1) | (NK'(1) << 5) | (NK'(1) << 6);

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [N-1:0]  cols;
  logic [N-1:0]  rows;
  logic [NK-1:0] pressed;
  logic [NK-1:0] new_press;
  logic          frame_done;

  // Sensed switch matrix: bit r*N+c closes row r onto column c.
  logic [NK-1:0] pat;

  int n_cmp = 0;
  int n_mis = 0;
  int np13  = 0;

  logic [NK-1:0] exp_pressed;
  logic [NK-1:0] exp_np;
  logic [NK-1:0] hist[$];

  key_matrix_scanner #(
    .N              (N),
    .SETTLE_CYCLES  (SC),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ena_i        (ena),
    .cols_o       (cols),
    .rows_i       (rows),
    .pressed_o    (pressed),
    .new_press_o  (new_press),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  // A row is pulled low when any closed switch on it touches a driven column.
  always_comb begin
    rows = '1;
    for (int i = 0; i < N; i++) begin
      rows[i] = ~|(pat[i*N +: N] & cols);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ghosty(input logic [NK-1:0] f);
    for (int a = 0; a < N; a++) begin
      for (int b = a + 1; b < N; b++) begin
        int both;
        both = 0;
        for (int c = 0; c < N; c++) begin
          if (f[a*N + c] && f[b*N + c]) both++;
        end
        if (both >= 2) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_pressed = '0;
    exp_np      = '0;
    hist.delete();
  endtask

  // Reference rule: the key map follows a frame once the last DS usable frames agree.
  task automatic model_frame(input logic [NK-1:0] f);
    bit g;
    bit stable;
    g = 1'b0;
`ifdef KEY_MATRIX_GHOST_REJECT_EN
    g = ghosty(f);
`endif
    if (g) begin
      hist.delete();
    end else begin
      hist.push_back(f);
      if (hist.size() > DS) void'(hist.pop_front());
    end
    stable = (hist.size() == DS);
    foreach (hist[k]) if (hist[k] != f) stable = 1'b0;
    if (stable && (f != exp_pressed)) begin
      exp_np      = f & ~exp_pressed;
      exp_pressed = f;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("pressed", pressed, exp_pressed);
    chk("new_press", new_press, exp_np);
    chk("cols_onehot", ($countones(cols) <= 1), 1);
    if (new_press[13]) np13++;
    exp_np = '0;
    if (frame_done) begin
      chk("cols_at_frame_end", cols, 0);
      model_frame(pat);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 4 * FRAME_LEN);
    chk("frame_done_seen", frame_done, 1);
  endtask

  task automatic run_frame(input logic [NK-1:0] p);
    pat = p;
    wait_frame();
  endtask

  initial begin
    logic [NK-1:0] rp;
    logic [N-1:0]  exp_c;
    int            q;

    rst = 1'b1;
    ena = 1'b0;
    pat = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Reset / idle
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_cols", cols, 0);
      chk("idle_frame_done", frame_done, 0);
    end

    // Scan order, two frames with no keys
    ena = 1'b1;
    for (int p = 0; p < 2 * FRAME_LEN; p++) begin
      tick();
      q = p % FRAME_LEN;
      exp_c = (q < FRAME_LEN - 1) ? (N'(1) << (q / (SC + 1))) : '0;
      chk("scan_cols", cols, exp_c);
      chk("scan_frame_done", frame_done, (q == FRAME_LEN - 1));
    end

    // Single press of (2,3)
    np13 = 0;
    for (int f = 0; f < 5; f++) run_frame(K13);
    chk("press13", pressed[13], 1);
    chk("press13_pulse_once", np13, 1);

    // Bounce on (0,0), then hold
    for (int f = 0; f < 6; f++) run_frame(K13 | (((f % 2) == 0) ? K0 : '0));
    chk("bounce_keeps0", pressed[0], 0);
    for (int f = 0; f < 3; f++) run_frame(K13 | K0);
    tick();
    chk("hold_press0", pressed[0], 1);

    // Release of key 13 with ena dropped mid-frame
    np13 = 0;
    pat = K0;
    for (int i = 0; i < 5; i++) tick();
    ena = 1'b0;
    wait_frame();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("drop_idle_cols", cols, 0);
      chk("drop_idle_frame_done", frame_done, 0);
    end
    chk("release_one_frame_holds13", pressed[13], 1);
    ena = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(K0);
    tick();
    chk("release13", pressed[13], 0);
    chk("release_no_pulse", np13, 0);

    // Ghost pattern (0,0),(0,1),(1,0) reading as (1,1) too
    for (int f = 0; f < 5; f++) run_frame(KG);
    tick();
`ifdef KEY_MATRIX_GHOST_REJECT_EN
    chk("ghost_pressed", pressed, K0);
`else
    chk("ghost_pressed", pressed, KG);
`endif

    // Randomized frames
    rp = '0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        rp = '0;
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) rp[$urandom_range(0, NK - 1)] = 1'b1;
      end
      run_frame(rp);
    end

    // Reset in the middle of a frame
    pat = K13 | K0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    model_reset();
    tick();
    chk("midrst_cols", cols, 0);
    chk("midrst_frame_done", frame_done, 0);
    rst = 1'b0;
    for (int f = 0; f < 4; f++) run_frame(K13);
    tick();
    chk("after_rst_press13", pressed, K13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Reads an N x N push-button matrix that shares the column/row wiring style of the Conway LED grid.
- Drives one column at a time and senses the active-low row lines.
- Debounces whole scan frames and presents a stable N*N key map plus one-cycle "newly pressed" events.
- Its key map feeds the cell-edit logic of the game-of-life top level. It is the input-side counterpart of the LED column/row driver.

Parameters:
- N, 5, matrix size; legal 1..8.
- SETTLE_CYCLES, 2, clocks a column is driven before rows are sampled; must be >= 1.
- DEBOUNCE_SCANS, 3, consecutive identical raw frames required before the key map updates; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  scan enable; when low, the scanner finishes the current frame, then idles.
- cols  output  N  one-hot, active-high column drive; all zero when idle.
- rows  input  N  row sense, active-low (0 = key at (row, driven col) pressed); assumed synchronized upstream.
- pressed  output  N*N  debounced key map; bit i*N+j = row i, col j; 1 = held.
- new_press  output  N*N  one-cycle pulse mask of keys that transitioned 0->1 in pressed.
- frame_done  output  1  one-cycle pulse at the end of every completed raw frame.

Behaviour:
- Reset: cols=0, pressed=0, new_press=0, frame_done=0, raw frame=0, previous frame=0, match count=0, column index=0, settle count=0, state=IDLE.
- FSM states: IDLE, DRIVE, SAMPLE, FRAME_END.
- IDLE:
  - cols=0.
  - If ena=1, go to DRIVE with column index 0 and settle count 0.
- DRIVE:
  - cols = 1<<column index.
  - Settle count increments each cycle.
  - After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle):
  - cols is still driven.
  - raw[i*N+col] <= ~rows[i] for all i.
  - If col==N-1, go to FRAME_END; else col++ and go to DRIVE.
- FRAME_END (one cycle):
  - cols=0; frame_done=1.
  - If raw==prev, match count saturates at DEBOUNCE_SCANS; else match count=1.
  - prev<=raw.
  - When match count reaches DEBOUNCE_SCANS (including this frame) and raw!=pressed:
    - pressed<=raw.
    - new_press<=raw & ~pressed, registered, visible the cycle after FRAME_END, width one cycle.
  - Next state is DRIVE (col=0) if ena=1, else IDLE.
- Frame length: N*(SETTLE_CYCLES+1)+1 clocks.
- ena deassert mid-frame: the frame completes normally; no partial update.
- DEBOUNCE_SCANS=1: every frame updates pressed directly.
- Releases clear bits in pressed with the same debounce rule; releases produce no new_press.
- rst mid-frame overrides everything: all state is cleared at the next edge, and partial raw data is discarded.
- Columns are never driven simultaneously; cols is never non-zero in IDLE or FRAME_END.

Optional Feature:
- Macro: KEY_MATRIX_GHOST_REJECT_EN.
- When defined, FRAME_END checks raw for ghosting: any two rows sharing >=2 pressed columns.
  - A ghosted frame does not update prev and resets match count to 0.
  - pressed holds its value; frame_done still pulses.
- When not defined, no check is made and all frames are used as-is.

Decomposition:
- Package key_matrix_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, FRAME_END);
  - a function for the column-counter width, $clog2(N) with a minimum of 1.
- One sub-module, key_frame_debouncer:
  - inputs: raw frame and frame strobe;
  - outputs: pressed and new_press;
  - owns prev, match count and the ghost check.
- The scan FSM stays in the top module.

Test Plan:
All cases use N=5, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3, so a frame is 16 clocks.
- Reset/idle:
  - Stimulus: rst high 2 cycles, ena=0 for 50 cycles.
  - Expected: cols=0, pressed=0, frame_done never pulses.
- Scan order:
  - Stimulus: ena=1, rows=5'b11111.
  - Expected: cols steps 00001,00010,...,10000, each held 3 clocks, then 00000 for 1 clock; frame_done pulses every 16 clocks.
- Single press:
  - Stimulus: hold key (row 2, col 3) low.
  - Expected: pressed[13]=1 after the 3rd identical frame; new_press==1<<13 for exactly one cycle; no further pulses while held.
- Bounce:
  - Stimulus: toggle key (0,0) on alternate frames for 6 frames.
  - Expected: pressed stays 0; then hold 3 frames → pressed[0]=1.
- Release and ena drop:
  - Stimulus: release key 13, deassert ena mid-frame.
  - Expected: the frame finishes, FSM enters IDLE, and pressed[13] stays 1 (only 1 release frame seen).
  - Stimulus: re-enable ena for 3 frames.
  - Expected: pressed[13]=0 with no new_press.
- Ghost reject (macro on):
  - Stimulus: press (0,0), (0,1), (1,0), which reads as 4 keys including ghost (1,1), for 5 frames.
  - Expected: pressed unchanged from its prior value.
  - Macro off, same stimulus: pressed bits 0,1,5,6 set.
